seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver_pkg.sv | 20 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seg7_scan_driver.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared state encoding and active-low segment patterns
package seg7_scan_driver_pkg;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-low seven-segment decoder
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_n
);

  // Non-decimal nibbles render as a dash rather than hex glyphs
  always_comb begin
    o_seg_n = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg_n = SEG_0;
      4'd1:    o_seg_n = SEG_1;
      4'd2:    o_seg_n = SEG_2;
      4'd3:    o_seg_n = SEG_3;
      4'd4:    o_seg_n = SEG_4;
      4'd5:    o_seg_n = SEG_5;
      4'd6:    o_seg_n = SEG_6;
      4'd7:    o_seg_n = SEG_7;
      4'd8:    o_seg_n = SEG_8;
      4'd9:    o_seg_n = SEG_9;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed seven-segment scanner with blanking gaps
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd,
  input  logic        ld,
  input  logic [3:0]  dp,
  input  logic        lzb,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t          r_state, w_nxt_state;
  logic [1:0]      r_idx, w_nxt_idx;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic            w_transfer;
  logic [15:0]     r_shadow, r_active;
  logic [3:0]      w_zero, w_blank, w_nibble, w_an_onehot;
  logic [6:0]      w_seg_n;
  logic            w_lit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= BLANK;
    else       r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt + CNT_ONE;
    w_transfer  = 1'b0;
    case (r_state)
      BLANK: if (r_cnt == BLANK_LAST) begin
        w_nxt_state = DRIVE;
        w_nxt_cnt   = '0;
      end
      DRIVE: if (r_cnt == DRIVE_LAST) begin
        w_nxt_state = BLANK;
        w_nxt_cnt   = '0;
        w_nxt_idx   = r_idx + 2'd1;
        w_transfer  = (r_idx == 2'd3);
      end
      default: w_nxt_state = BLANK;
    endcase
  end

  // A digit is blanked only when it and every more significant digit are zero
  assign w_zero[0]  = (r_active[3:0]   == 4'd0);
  assign w_zero[1]  = (r_active[7:4]   == 4'd0);
  assign w_zero[2]  = (r_active[11:8]  == 4'd0);
  assign w_zero[3]  = (r_active[15:12] == 4'd0);
  assign w_blank[0] = 1'b0;
  assign w_blank[3] = lzb & w_zero[3];
  assign w_blank[2] = w_blank[3] & w_zero[2];
  assign w_blank[1] = w_blank[2] & w_zero[1];

  // Outputs are computed from the next state so they flip on the transition edge
  assign w_nibble    = r_active[{w_nxt_idx, 2'b00} +: 4];
  assign w_an_onehot = ~(4'b0001 << w_nxt_idx);
  assign w_lit       = (w_nxt_state == DRIVE) && !w_blank[w_nxt_idx];

  bcd_to_seg7 u_dec (
    .i_bcd   (w_nibble),
    .o_seg_n (w_seg_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= 2'd0;
      r_cnt    <= '0;
      r_shadow <= 16'h0000;
      r_active <= 16'h0000;
      seg_n    <= SEG_OFF;
      dp_n     <= 1'b1;
      an_n     <= 4'hF;
      frame    <= 1'b0;
    end else begin
      r_idx <= w_nxt_idx;
      r_cnt <= w_nxt_cnt;
      frame <= w_transfer;
      if (ld)         r_shadow <= bcd;
      if (w_transfer) r_active <= r_shadow;
      if (w_lit) begin
        an_n  <= w_an_onehot;
        seg_n <= w_seg_n;
        dp_n  <= ~dp[w_nxt_idx];
      end else begin
        an_n  <= 4'hF;
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule
